// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32 fetch path
package core_pkg;
  typedef logic [31:0] addr_t;
  typedef enum logic [1:0] {BOOT, RUN, WAIT, TRAP} pc_state_t;
  localparam addr_t PC_STEP = 32'd4;
  localparam addr_t RESET_VECTOR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/redirect_buf.sv
// redirect_buf: single-entry redirect target holder; load overwrites, clear drops valid
module redirect_buf
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clr,
  input  addr_t din,
  output logic  valid,
  output addr_t q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q <= din;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch PC sequencing with memory-wait hold, redirect buffering, flush and misalign trap
module next_pc_unit
  import core_pkg::*;
#(
  parameter addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int    XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bSel,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            flush,
  output logic            misalign,
  output logic [15:0]     redirect_cnt
);
  pc_state_t state, state_n;
  logic [XLEN-1:0] pc_n;
  logic redirect, live, bad, take, buf_load, buf_clr, buf_valid;
  addr_t buf_q;
  assign redirect = bSel | jump;
  assign live = (state == RUN) || (state == WAIT);
  assign bad = live & redirect & ~stall & (target[1:0] != 2'b00);
  assign take = live & redirect & ~stall & ~bad;
  assign pc_plus4 = pc + PC_STEP;
  assign fetch_valid = live;
  redirect_buf u_buf (
    .clk(clk), .rst(rst), .load(buf_load), .clr(buf_clr),
    .din(target), .valid(buf_valid), .q(buf_q)
  );
  always_comb begin
    state_n = state;
    pc_n = pc;
    buf_load = 1'b0;
    buf_clr = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN:
        if (bad) state_n = TRAP;
        else if (take) pc_n = target;
        else if (!stall) begin
          if (!imem_ready) state_n = WAIT;
          else pc_n = pc_plus4;
        end
      WAIT:
        if (bad) state_n = TRAP;
        else if (take && !imem_ready) buf_load = 1'b1;
        else if (!stall && imem_ready) begin
          // a live redirect outranks whatever is parked in the buffer
          state_n = RUN;
          buf_clr = 1'b1;
          pc_n = take ? target : buf_valid ? buf_q : pc_plus4;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_VECTOR;
      flush <= 1'b0;
      misalign <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      flush <= take;
      misalign <= misalign | bad;
      if (take && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed plan plus random traffic checked each cycle against a behavioural model
module tb_next_pc_unit;
  logic clk = 1'b0, rst = 1'b0, bSel = 1'b0, jump = 1'b0, stall = 1'b0, imem_ready = 1'b0;
  logic [31:0] target = '0, pc, pc_plus4;
  logic fetch_valid, flush, misalign;
  logic [15:0] redirect_cnt;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_pc;
  bit m_boot, m_trap, m_wait, m_flush, m_mis;
  int m_cnt;
  logic [31:0] pend[$];

  next_pc_unit dut (
    .clk(clk), .rst(rst), .bSel(bSel), .jump(jump), .target(target), .stall(stall),
    .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .flush(flush), .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic model(input bit r, b, j, s, rdy, input logic [31:0] t);
    bit red, fl;
    red = b | j;
    fl = 1'b0;
    if (r) begin
      m_pc = 32'h0; m_boot = 1; m_trap = 0; m_wait = 0; m_mis = 0; m_cnt = 0;
      pend.delete();
    end else if (m_boot) m_boot = 0;
    else if (!m_trap) begin
      if (red && !s && t[1:0] != 2'b00) begin m_trap = 1; m_mis = 1; end
      else if (s) ;
      else if (red) begin
        fl = 1;
        if (m_cnt < 65535) m_cnt++;
        pend.delete();
        if (!m_wait || rdy) begin m_pc = t; m_wait = 0; end
        else pend.push_back(t);
      end else if (!rdy) m_wait = 1;
      else begin
        m_pc = (pend.size() != 0) ? pend.pop_front() : m_pc + 32'd4;
        m_wait = 0;
      end
    end
    m_flush = fl;
  endtask

  task automatic step(input bit r, b, j, s, rdy, input logic [31:0] t);
    rst = r; bSel = b; jump = j; stall = s; imem_ready = rdy; target = t;
    @(posedge clk);
    model(r, b, j, s, rdy, t);
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    checks++;
    if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || fetch_valid !== (!m_boot && !m_trap) ||
        flush !== m_flush || misalign !== m_mis || redirect_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL model t=%0t pc=%h/%h p4=%h fv=%b/%b fl=%b/%b mis=%b/%b cnt=%0d/%0d",
               $time, pc, m_pc, pc_plus4, fetch_valid, !m_boot && !m_trap, flush, m_flush,
               misalign, m_mis, redirect_cnt, m_cnt);
    end
  end

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    lit("boot_pc", pc, 32'h0);
    lit("boot_fv", 32'(fetch_valid), 32'h0);
    step(0, 0, 0, 0, 1, 0);
    lit("run_pc0", pc, 32'h0);
    lit("run_fv", 32'(fetch_valid), 32'h1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    lit("run_pc12", pc, 32'hC);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 32'h40);
    lit("br_pc", pc, 32'h40);
    lit("br_flush", 32'(flush), 32'h1);
    lit("br_cnt", 32'(redirect_cnt), 32'h1);
    step(0, 0, 0, 0, 1, 0);
    lit("br_next", pc, 32'h44);
    lit("br_flush_off", 32'(flush), 32'h0);
    step(0, 1, 0, 1, 1, 32'h80);
    lit("stall_pc", pc, 32'h44);
    lit("stall_flush", 32'(flush), 32'h0);
    step(0, 1, 0, 0, 1, 32'h80);
    lit("unstall_pc", pc, 32'h80);
    lit("unstall_flush", 32'(flush), 32'h1);
    step(0, 1, 0, 0, 1, 32'h20);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 32'h100);
    lit("wait_fl1", 32'(flush), 32'h1);
    step(0, 1, 0, 0, 0, 32'h200);
    lit("wait_fl2", 32'(flush), 32'h1);
    lit("wait_pc", pc, 32'h20);
    lit("wait_cnt", 32'(redirect_cnt), 32'h5);
    step(0, 0, 0, 0, 1, 0);
    lit("buf_pc", pc, 32'h200);
    step(0, 0, 0, 0, 1, 0);
    lit("buf_next", pc, 32'h204);
    step(0, 1, 0, 0, 1, 32'h42);
    lit("trap_mis", 32'(misalign), 32'h1);
    lit("trap_fv", 32'(fetch_valid), 32'h0);
    step(0, 1, 1, 0, 1, 32'h300);
    step(0, 0, 0, 0, 1, 0);
    lit("trap_pc", pc, 32'h204);
    step(1, 0, 0, 0, 1, 0);
    lit("rst_pc", pc, 32'h0);
    lit("rst_mis", 32'(misalign), 32'h0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    lit("wrap_top", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 0);
    lit("wrap_zero", pc, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom() & ~32'h3;
      if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, t);
    end
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, 1, 32'h100);
    lit("sat_cnt", 32'(redirect_cnt), 32'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Program-counter / next-PC stage for the RV32 core.
- Sits downstream of branchCtrl: consumes its 1-bit bSel taken decision, plus jump requests and the resolved target, and produces the fetch PC for instruction memory.
- Owns PC sequencing, memory-wait holding, redirect buffering, the one-cycle pipeline flush pulse and misaligned-target trapping.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- bSel  input  1  branch taken, from branchCtrl (EX stage).
- jump  input  1  JAL/JALR taken, from EX stage.
- target  input  32  resolved branch/jump target; bit 0 already cleared by EX for JALR.
- stall  input  1  hazard stall; freezes PC and suppresses redirect acceptance.
- imem_ready  input  1  instruction memory accepts the current fetch address this cycle.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + 4, combinational.
- fetch_valid  output  1  pc is a live fetch request.
- flush  output  1  one-cycle pulse; IF/ID and ID/EX must squash.
- misalign  output  1  sticky trap flag: taken target with target[1:0] != 0.
- redirect_cnt  output  16  count of accepted redirects; saturates at 16'hFFFF.

Behaviour:
- Reset (rst = 1 at an edge):
  - pc = RESET_VECTOR; fetch_valid = 0; flush = 0; misalign = 0; redirect_cnt = 0; pending buffer cleared; state = BOOT.
  - Reset asserted mid-operation overrides everything, including a pending redirect.
- redirect = bSel | jump. target is used identically for both sources.
- States:
  - BOOT: single cycle, fetch_valid = 0, then RUN unconditionally. A redirect in BOOT is ignored.
  - RUN: fetch_valid = 1. Priority order:
    - rst
    - misaligned redirect: misalign <= 1, go to TRAP, pc holds, no flush.
    - stall = 1: pc holds, redirect ignored; EX re-presents it after the stall.
    - redirect: pc <= target, flush = 1 next cycle, redirect_cnt += 1.
    - imem_ready = 0: pc holds, go to WAIT.
    - otherwise: pc <= pc + 4, wrapping mod 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - WAIT: fetch_valid = 1 and pc holds until imem_ready = 1.
    - A redirect arriving in WAIT (stall = 0) is captured in a 1-entry pending buffer (target + valid). flush pulses the next cycle and redirect_cnt increments at capture time.
    - Later redirects while the buffer is valid overwrite the buffer (youngest wins), pulse flush again and count again.
    - On imem_ready = 1:
      - buffer valid: pc <= buffered target, buffer cleared, go to RUN.
      - buffer empty: pc <= pc + 4, go to RUN.
    - A redirect and imem_ready = 1 in the same cycle: the live redirect wins, pc <= target, buffer cleared.
  - TRAP: fetch_valid = 0, pc frozen, misalign = 1. Only rst exits TRAP.
- flush is registered: high exactly one cycle after the accepting edge. Back-to-back accepted redirects give back-to-back flush cycles.
- Misalignment is checked only when redirect = 1 and stall = 0. It is checked in both RUN and WAIT; in WAIT a misaligned redirect also goes to TRAP.
- redirect_cnt saturates at 16'hFFFF and does not wrap.

Decomposition:
- Shared package core_pkg:
  - typedef pc_state_t {BOOT, RUN, WAIT, TRAP}.
  - Constants PC_STEP = 4 and RESET_VECTOR_DEFAULT.
  - typedef addr_t = logic [31:0].
- Sub-module redirect_buf: 1-entry target holding register with valid, load/overwrite and clear.
- The FSM, PC register, flush register and counter stay in next_pc_unit.

Test Plan:
- Reset/boot: rst = 1 for 2 cycles, then 0 with imem_ready = 1 → cycle 0 pc = 0, fetch_valid = 0; then pc = 0, 4, 8, 12 with fetch_valid = 1.
- Branch taken: at pc = 32'h10, bSel = 1, target = 32'h40 for 1 cycle → next pc = 32'h40, flush high for exactly one cycle, redirect_cnt = 1, then pc = 32'h44.
- Stall priority: stall = 1 and bSel = 1, target = 32'h80 → pc holds, no flush, cnt unchanged. Drop stall with bSel still 1 → pc = 32'h80, flush pulse.
- Memory wait + buffering: imem_ready = 0 at pc = 32'h20; jump = 1, target = 32'h100, then bSel = 1, target = 32'h200 in WAIT → two flush pulses, cnt += 2. imem_ready = 1 → pc = 32'h200, then 32'h204.
- Misalign trap: bSel = 1, target = 32'h0000_0042 → misalign = 1, fetch_valid = 0, pc frozen until rst. rst → pc = RESET_VECTOR, misalign = 0.
- Wrap and saturation: force pc to 32'hFFFF_FFFC → next pc = 32'h0. Issue 65536 redirects → redirect_cnt stays at 16'hFFFF.
